// File: rtl/toaplan2_eeprom_93c46.sv
// toaplan2_eeprom_93c46: 93C46 (64 x 16) serial EEPROM responder for the 68K bit-bang lines.
// Ports: CLK, RESET (async, active high), EEPROM_SCS/SCLK/SDI in, EEPROM_SDO out.
// Define EEPROM_NVRAM_EN to add the NV_ADDR/NV_WE/NV_DIN/NV_DOUT/NV_DIRTY host save/load port.
module toaplan2_eeprom_93c46 #(
    parameter int          BUSY_CYCLES = 4800,
    parameter logic [15:0] INIT_WORD   = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EEPROM_SCS,
    input  logic        EEPROM_SCLK,
    input  logic        EEPROM_SDI,
    output logic        EEPROM_SDO
`ifdef EEPROM_NVRAM_EN
    ,
    input  logic [5:0]  NV_ADDR,
    input  logic        NV_WE,
    input  logic [15:0] NV_DIN,
    output logic [15:0] NV_DOUT,
    output logic        NV_DIRTY
`endif
);

    // Busy must cover the 64-cycle bulk sweep.
    localparam int BUSY_N = (BUSY_CYCLES > 64) ? BUSY_CYCLES : 64;
    localparam int BW     = $clog2(BUSY_N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_READ, S_WDATA, S_WAIT_CS, S_BUSY
    } state_t;

    typedef enum logic [2:0] {
        P_NONE, P_WRITE, P_ERASE, P_ERAL, P_WRAL
    } pend_t;

    state_t        state, state_n;
    pend_t         pend;
    logic [1:0]    scs_ff, sclk_ff, sdi_ff;
    logic          sclk_d;
    logic          scs, sdi, rise;
    logic [15:0]   sr;
    logic [3:0]    cnt;
    logic [5:0]    addr;
    logic          wen;
    logic          rd_bit;
    logic [BW-1:0] bcnt;
    logic [7:0]    cmd;
    logic          commit, bulk, ser_we;
    logic          mem_we;
    logic [5:0]    mem_wa;
    logic [15:0]   mem_wd;

    // Storage is never reset; it only holds INIT_WORD from configuration.
    logic [15:0]   mem [64] = '{default: INIT_WORD};

    assign scs  = scs_ff[1];
    assign sdi  = sdi_ff[1];
    assign rise = sclk_ff[1] & ~sclk_d;
    assign cmd  = {sr[6:0], sdi};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scs_ff  <= '0;
            sclk_ff <= '0;
            sdi_ff  <= '0;
            sclk_d  <= 1'b0;
        end else begin
            scs_ff  <= {scs_ff[0], EEPROM_SCS};
            sclk_ff <= {sclk_ff[0], EEPROM_SCLK};
            sdi_ff  <= {sdi_ff[0], EEPROM_SDI};
            sclk_d  <= sclk_ff[1];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:
                if (scs && rise && sdi) state_n = S_CMD;
            S_CMD:
                if (!scs) state_n = S_IDLE;
                else if (rise && cnt == 4'd7) begin
                    case (cmd[7:6])
                        2'b10:   state_n = S_READ;
                        2'b01:   state_n = S_WDATA;
                        2'b11:   state_n = S_WAIT_CS;
                        default: state_n = (cmd[5:4] == 2'b01) ? S_WDATA : S_WAIT_CS;
                    endcase
                end
            S_READ:
                if (!scs) state_n = S_IDLE;
            S_WDATA:
                if (!scs) state_n = S_IDLE;
                else if (rise && cnt == 4'd15) state_n = S_WAIT_CS;
            S_WAIT_CS:
                if (!scs) state_n = (pend != P_NONE && wen) ? S_BUSY : S_IDLE;
            S_BUSY:
                if (bcnt == BW'(BUSY_N - 1)) state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
    end

    always_comb begin
        EEPROM_SDO = 1'b1;
        if (scs) begin
            case (state)
                S_BUSY:  EEPROM_SDO = 1'b0;
                S_READ:  EEPROM_SDO = rd_bit;
                default: EEPROM_SDO = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt    <= '0;
            sr     <= '0;
            addr   <= '0;
            pend   <= P_NONE;
            wen    <= 1'b0;
            rd_bit <= 1'b1;
            bcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    bcnt   <= '0;
                    pend   <= P_NONE;
                    rd_bit <= 1'b1;
                end
                S_CMD:
                    if (scs && rise) begin
                        sr  <= {sr[14:0], sdi};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt  <= '0;
                            addr <= cmd[5:0];
                            case (cmd[7:6])
                                2'b10: begin
                                    sr     <= mem[cmd[5:0]];
                                    rd_bit <= 1'b0;
                                end
                                2'b01: pend <= P_WRITE;
                                2'b11: pend <= P_ERASE;
                                default:
                                    case (cmd[5:4])
                                        2'b11:   wen  <= 1'b1;
                                        2'b00:   wen  <= 1'b0;
                                        2'b10:   pend <= P_ERAL;
                                        default: pend <= P_WRAL;
                                    endcase
                            endcase
                        end
                    end
                S_READ:
                    if (scs && rise) begin
                        rd_bit <= sr[15];
                        sr     <= {sr[14:0], 1'b0};
                        cnt    <= cnt + 4'd1;
                        // D0 is leaving: queue the next word, no dummy bit.
                        if (cnt == 4'd15) begin
                            addr <= addr + 6'd1;
                            sr   <= mem[addr + 6'd1];
                        end
                    end
                S_WDATA:
                    if (scs && rise) begin
                        sr  <= {sr[14:0], sdi};
                        cnt <= cnt + 4'd1;
                    end
                S_WAIT_CS:
                    bcnt <= '0;
                S_BUSY:
                    bcnt <= bcnt + BW'(1);
                default: ;
            endcase
        end
    end

    // Single words land at the commit; bulk ops sweep one word per CLK during busy.
    always_comb begin
        commit = (state == S_WAIT_CS) && !scs && wen && (pend != P_NONE);
        bulk   = (state == S_BUSY) && (pend == P_ERAL || pend == P_WRAL)
                 && (bcnt < BW'(64));
        ser_we = bulk || (commit && (pend == P_WRITE || pend == P_ERASE));
        mem_we = ser_we;
        mem_wa = bulk ? bcnt[5:0] : addr;
        mem_wd = (pend == P_ERASE || pend == P_ERAL) ? 16'hFFFF : sr;
`ifdef EEPROM_NVRAM_EN
        // Serial programming wins; a colliding host write is dropped.
        if (!ser_we && NV_WE) begin
            mem_we = 1'b1;
            mem_wa = NV_ADDR;
            mem_wd = NV_DIN;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
`ifdef EEPROM_NVRAM_EN
        NV_DOUT <= mem[NV_ADDR];
`endif
    end

`ifdef EEPROM_NVRAM_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            NV_DIRTY <= 1'b0;
        else if (commit)
            NV_DIRTY <= 1'b1;
        else if (NV_WE && !ser_we && NV_ADDR == 6'd63)
            NV_DIRTY <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_toaplan2_eeprom_93c46.sv
// tb_toaplan2_eeprom_93c46: scoreboard bench for the 93C46 responder.
// A driver bit-bangs commands and queues expected values; a monitor pops and compares.
module tb_toaplan2_eeprom_93c46;

    localparam int BC = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scs = 1'b0;
    logic sclk = 1'b0;
    logic sdi = 1'b0;
    logic sdo;
`ifdef EEPROM_NVRAM_EN
    logic [5:0]  nv_addr = '0;
    logic        nv_we = 1'b0;
    logic [15:0] nv_din = '0;
    logic [15:0] nv_dout;
    logic        nv_dirty;
`endif

    always #5 clk = ~clk;

    toaplan2_eeprom_93c46 #(.BUSY_CYCLES(BC)) dut (
        .CLK(clk),
        .RESET(rst),
        .EEPROM_SCS(scs),
        .EEPROM_SCLK(sclk),
        .EEPROM_SDI(sdi),
        .EEPROM_SDO(sdo)
`ifdef EEPROM_NVRAM_EN
        ,
        .NV_ADDR(nv_addr),
        .NV_WE(nv_we),
        .NV_DIN(nv_din),
        .NV_DOUT(nv_dout),
        .NV_DIRTY(nv_dirty)
`endif
    );

    // Reference model: plain word array plus write-enable flag.
    logic [15:0] model [64];
    bit          wen_m;

    logic [15:0] exp_q [$];
    int          sel_q [$];
    string       nm_q  [$];
    logic        stb = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always @(negedge clk) begin
        if (stb) begin
            logic [15:0] e, a;
            int          s;
            string       n;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: sample with no expectation");
            end else begin
                e = exp_q.pop_front();
                s = sel_q.pop_front();
                n = nm_q.pop_front();
                a = {15'b0, sdo};
`ifdef EEPROM_NVRAM_EN
                if (s == 1) a = nv_dout;
                if (s == 2) a = {15'b0, nv_dirty};
`endif
                if (a !== e) begin
                    fails++;
                    $display("FAIL %s: got %h want %h (sel %0d)", n, a, e, s);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int sel, input logic [15:0] v, input string nm);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        nm_q.push_back(nm);
        stb = 1'b1;
        tick(1);
        stb = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sdi  = b;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic select();
        scs  = 1'b1;
        sclk = 1'b0;
        sdi  = 1'b0;
        tick(4);
    endtask

    task automatic deselect();
        sclk = 1'b0;
        scs  = 1'b0;
        tick(4);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] a);
        send_bit(1'b1);
        send_bit(op[1]);
        send_bit(op[0]);
        for (int i = 5; i >= 0; i--) send_bit(a[i]);
    endtask

    task automatic do_read(input int a, input int nw);
        logic [15:0] w;
        select();
        send_cmd(2'b10, 6'(a));
        expect_v(0, 16'd0, "read_dummy");
        for (int k = 0; k < nw; k++) begin
            w = model[(a + k) % 64];
            for (int i = 15; i >= 0; i--) begin
                send_bit(1'($urandom_range(0, 1)));
                expect_v(0, {15'b0, w[i]}, "read_bit");
            end
        end
        deselect();
        expect_v(0, 16'd1, "sdo_cs_low");
    endtask

    // op/a select the instruction; data is shifted only for WRITE/WRAL.
    task automatic prog(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d);
        bit has_data, busy;
        has_data = (op == 2'b01) || (op == 2'b00 && a[5:4] == 2'b01);
        busy = wen_m && (op != 2'b00 || a[5:4] == 2'b01 || a[5:4] == 2'b10);
        select();
        send_cmd(op, a);
        if (has_data)
            for (int i = 15; i >= 0; i--) send_bit(d[i]);
        deselect();
        if (busy) begin
            if (op == 2'b01) model[a] = d;
            if (op == 2'b11) model[a] = 16'hFFFF;
            if (op == 2'b00)
                for (int i = 0; i < 64; i++)
                    model[i] = (a[5:4] == 2'b10) ? 16'hFFFF : d;
        end
        if (op == 2'b00 && a[5:4] == 2'b11) wen_m = 1'b1;
        if (op == 2'b00 && a[5:4] == 2'b00) wen_m = 1'b0;
        scs = 1'b1;
        tick(4);
        expect_v(0, busy ? 16'd0 : 16'd1, "busy_start");
        if (busy) begin
            tick(BC - 20);
            expect_v(0, 16'd0, "busy_late");
            tick(30);
            expect_v(0, 16'd1, "ready");
        end
        deselect();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
        wen_m = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        expect_v(0, 16'd1, "reset_sdo_cs_low");
        select();
        expect_v(0, 16'd1, "reset_sdo_idle");
        deselect();
`ifdef EEPROM_NVRAM_EN
        expect_v(2, 16'd0, "nv_dirty_reset");
`endif
        // Power-up content and write protection.
        do_read(5, 1);
        prog(2'b01, 6'd3, 16'h1234);
        do_read(3, 1);
        // Enable, write, sequential read with wrap.
        prog(2'b00, 6'h30, 16'h0);
        prog(2'b01, 6'd3, 16'h1234);
        do_read(3, 1);
        prog(2'b01, 6'd63, 16'hABCD);
        prog(2'b01, 6'd0, 16'h5A5A);
        do_read(63, 2);
        // Abort mid-data.
        select();
        send_cmd(2'b01, 6'd7);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        deselect();
        expect_v(0, 16'd1, "abort_sdo");
        do_read(7, 1);
        // Reset clears write enable but not storage.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        wen_m = 1'b0;
        tick(2);
        prog(2'b01, 6'd3, 16'h7777);
        do_read(3, 1);
        prog(2'b00, 6'h30, 16'h0);
        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)
                prog(2'b01, 6'($urandom_range(0, 63)), 16'($urandom));
            else if (r == 5)
                prog(2'b11, 6'($urandom_range(0, 63)), 16'h0);
            else if (r <= 8)
                do_read($urandom_range(0, 63), $urandom_range(1, 2));
            else
                prog(2'b00, ($urandom_range(0, 1) != 0) ? 6'h30 : 6'h00, 16'h0);
        end
        // Bulk operations.
        prog(2'b00, 6'h30, 16'h0);
        prog(2'b00, 6'h10, 16'h0F0F);
        do_read(62, 4);
        prog(2'b00, 6'h20, 16'h0);
        do_read(0, 64);
`ifdef EEPROM_NVRAM_EN
        expect_v(2, 16'd1, "nv_dirty_set");
        nv_addr = 6'd20;
        tick(1);
        expect_v(1, model[20], "nv_dout_20");
        nv_we  = 1'b1;
        nv_addr = 6'd63;
        nv_din = 16'h4321;
        tick(1);
        nv_we = 1'b0;
        model[63] = 16'h4321;
        tick(1);
        expect_v(2, 16'd0, "nv_dirty_clear");
        do_read(63, 1);
`endif
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
